// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - multiplexed BCD seven-segment scan driver with double-buffered digits
// Optional hex glyphs for codes 10..15 enabled by defining SEG_HEX_EN.
module bcd_scan_display #(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter int ACTIVE_LOW_AN = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [7:0]              segment,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0]        div_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic [4*NUM_DIGITS-1:0] active_bcd;
    logic [NUM_DIGITS-1:0]   active_dp;
    logic [4*NUM_DIGITS-1:0] pending_bcd;
    logic [NUM_DIGITS-1:0]   pending_dp;
    logic                    pending_valid;

    logic                    tick;
    logic                    frame_wrap;
    logic [3:0]              cur_digit;
    logic [7:0]              code;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic                    seen_nz;
    logic [7:0]              segment_nxt;
    logic [NUM_DIGITS-1:0]   an_onehot;

    function automatic logic [7:0] decode(input logic [3:0] v);
        logic [7:0] c;
        case (v)
            4'd0:    c = 8'hFC;
            4'd1:    c = 8'h60;
            4'd2:    c = 8'hDA;
            4'd3:    c = 8'hF2;
            4'd4:    c = 8'h66;
            4'd5:    c = 8'hB6;
            4'd6:    c = 8'hBE;
            4'd7:    c = 8'hE0;
            4'd8:    c = 8'hFE;
            4'd9:    c = 8'hF6;
`ifdef SEG_HEX_EN
            4'd10:   c = 8'hEE;
            4'd11:   c = 8'h3E;
            4'd12:   c = 8'h9C;
            4'd13:   c = 8'h7A;
            4'd14:   c = 8'h9E;
            default: c = 8'h8E;
`else
            default: c = 8'h00;
`endif
        endcase
        return c;
    endfunction

    assign tick       = (div_cnt == LAST_DIV);
    assign frame_wrap = tick && (digit_idx == LAST_IDX);

    always_comb begin
        cur_digit  = active_bcd[{digit_idx, 2'b00} +: 4];
        seen_nz    = 1'b0;
        blank_mask = '0;
        // Walk from the most significant digit; blank zeros until the first nonzero.
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (active_bcd[4*i +: 4] != 4'd0) begin
                seen_nz = 1'b1;
            end
            blank_mask[i] = ~seen_nz;
        end
        code        = decode(cur_digit);
        segment_nxt = {code[7:1], active_dp[digit_idx]};
        if (blank_lz && blank_mask[digit_idx]) begin
            segment_nxt[7:1] = 7'd0;
        end
        an_onehot            = '0;
        an_onehot[digit_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt       <= '0;
            digit_idx     <= '0;
            active_bcd    <= '0;
            active_dp     <= '0;
            pending_bcd   <= '0;
            pending_dp    <= '0;
            pending_valid <= 1'b0;
            segment       <= 8'h00;
            anode         <= (ACTIVE_LOW_AN != 0) ? '1 : '0;
            frame_done    <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
            end
            if (frame_wrap && pending_valid) begin
                active_bcd    <= pending_bcd;
                active_dp     <= pending_dp;
                pending_valid <= 1'b0;
            end
            // A load on the commit cycle lands in pending after the old value moves out.
            if (load) begin
                pending_bcd   <= bcd_in;
                pending_dp    <= dp_in;
                pending_valid <= 1'b1;
            end
            segment    <= segment_nxt;
            anode      <= (ACTIVE_LOW_AN != 0) ? ~an_onehot : an_onehot;
            frame_done <= frame_wrap;
        end
    end

endmodule
